bm_prod_accum: RTL and testbench

- Downstream consumer of the multiplier microbenchmark products.
- Accepts unsigned IN_W-bit products over a valid/ready stream and sums a programmable-length window of beats.
- Presents the window sum on a one-entry output register with valid/ready handshake.
- Used to benchmark synthesis of adder-accumulator, counter, FSM and handshake logic fed by multiplier outputs.

---
 rtl/bm_prod_accum_if.sv | 31 +++
 rtl/bm_prod_accum.sv | 130 +++++++++++++
 tb/tb_bm_prod_accum.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bm_prod_accum_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bm_prod_accum_if                                                         |
// | Product input stream and window-sum output stream of bm_prod_accum.      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface bm_prod_accum_if #(
  parameter int IN_W  = 18,
  parameter int ACC_W = 24,
  parameter int CNT_W = 8
) ();
  logic [IN_W-1:0]  in_data;
  logic             in_valid;
  logic             in_ready;
  logic [CNT_W-1:0] len;
  logic [ACC_W-1:0] acc_out;
  logic             acc_valid;
  logic             acc_ready;
  logic             ovf;

  modport master (
    output in_data, in_valid, len, acc_ready,
    input  in_ready, acc_out, acc_valid, ovf
  );

  modport slave (
    input  in_data, in_valid, len, acc_ready,
    output in_ready, acc_out, acc_valid, ovf
  );
endinterface
`default_nettype wire

// File: rtl/bm_prod_accum.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bm_prod_accum                                                            |
// | Sums a programmable-length window of product beats and presents the     |
// | sum on a one-entry valid/ready output register.                          |
// | Optional macro BM_PROD_ACCUM_SATURATE_EN: clamp on overflow, else wrap.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module bm_prod_accum #(
  parameter int IN_W  = 18,
  parameter int ACC_W = 24,
  parameter int CNT_W = 8
) (
  input wire           clock,
  input wire           reset,
  bm_prod_accum_if.slave bus
);
  localparam int SUM_W = ACC_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] acc_out_q, acc_out_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic             ovf_q, ovf_d;
  logic             in_ready_q, in_ready_d;
  logic             acc_valid_q, acc_valid_d;

  logic             w_in_xfer;
  logic             w_out_xfer;
  logic [SUM_W-1:0] w_sum;
  logic             w_carry;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [CNT_W-1:0] w_len_eff;

  assign w_in_xfer  = bus.in_valid & in_ready_q;
  assign w_out_xfer = acc_valid_q & bus.acc_ready;
  assign w_sum      = SUM_W'(acc_q) + SUM_W'(bus.in_data);
  assign w_carry    = w_sum[ACC_W];
  assign w_cnt_inc  = cnt_q + CNT_W'(1);
  // A zero length would never terminate the window, so it means one beat.
  assign w_len_eff  = (bus.len == '0) ? CNT_W'(1) : bus.len;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    acc_out_d = acc_out_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    ovf_d     = ovf_q;

    unique case (state_q)
      IDLE: begin
        if (w_in_xfer) begin
          acc_d = ACC_W'(bus.in_data);
          cnt_d = CNT_W'(1);
          ovf_d = 1'b0;
          len_d = w_len_eff;
          if (w_len_eff == CNT_W'(1)) begin
            acc_out_d = ACC_W'(bus.in_data);
            state_d   = FULL;
          end else begin
            state_d = ACCUM;
          end
        end
      end
      ACCUM: begin
        if (w_in_xfer) begin
`ifdef BM_PROD_ACCUM_SATURATE_EN
          acc_d = (w_carry | ovf_q) ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
`else
          acc_d = w_sum[ACC_W-1:0];
`endif
          cnt_d = w_cnt_inc;
          ovf_d = ovf_q | w_carry;
          if (w_cnt_inc == len_q) begin
            acc_out_d = acc_d;
            state_d   = FULL;
          end
        end
      end
      FULL: begin
        // No bypass: the next window's first beat waits one cycle after the drain.
        if (w_out_xfer) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    in_ready_d  = (state_d != FULL);
    acc_valid_d = (state_d == FULL);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      acc_out_q   <= '0;
      cnt_q       <= '0;
      len_q       <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      acc_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      acc_out_q   <= acc_out_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      acc_valid_q <= acc_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.acc_valid = acc_valid_q;
  assign bus.acc_out   = acc_out_q;
  assign bus.ovf       = ovf_q;
endmodule
`default_nettype wire

// File: tb/tb_bm_prod_accum.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_bm_prod_accum                                                         |
// | Directed and randomized windows checked against an exact-integer model.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_bm_prod_accum;
  localparam int     IN_W    = 18;
  localparam int     ACC_W   = 24;
  localparam int     CNT_W   = 8;
  localparam longint ACC_MOD = 64'd1 << ACC_W;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  bm_prod_accum_if #(.IN_W(IN_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

  bm_prod_accum #(.IN_W(IN_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;
  bit rnd_ar = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Reference: whole-window integer sum, reduced only when the window closes.
  bit     m_live = 1'b0;
  bit     m_full, m_in_win, m_ovf;
  int     m_len, m_cnt;
  longint m_sum, m_out;

  always @(posedge clock) begin
    if (reset) begin
      m_live   = 1'b1;
      m_full   = 1'b0;
      m_in_win = 1'b0;
    end else if (m_live) begin
      if (m_full) begin
        if (bus.acc_ready) m_full = 1'b0;
      end else if (bus.in_valid) begin
        if (!m_in_win) begin
          m_in_win = 1'b1;
          m_len    = (bus.len == '0) ? 1 : int'(bus.len);
          m_cnt    = 0;
          m_sum    = 0;
        end
        m_cnt++;
        m_sum += longint'(bus.in_data);
        if (m_cnt == m_len) begin
          m_in_win = 1'b0;
          m_full   = 1'b1;
          m_ovf    = (m_sum >= ACC_MOD);
`ifdef BM_PROD_ACCUM_SATURATE_EN
          m_out    = m_ovf ? ACC_MOD - 1 : m_sum;
`else
          m_out    = m_sum % ACC_MOD;
`endif
        end
      end
    end
  end

  always @(negedge clock) begin
    if (m_live) begin
      chk("in_ready", 64'(bus.in_ready), 64'(!m_full));
      chk("acc_valid", 64'(bus.acc_valid), 64'(m_full));
      if (m_full) begin
        chk("acc_out", 64'(bus.acc_out), 64'(m_out));
        chk("ovf", 64'(bus.ovf), 64'(m_ovf));
      end
    end
  end

  // Called at a negedge; returns at the negedge after the beat transferred.
  task automatic send_beat(input logic [IN_W-1:0] d, input logic [CNT_W-1:0] l);
    logic rdy;
    bus.in_data  = d;
    bus.len      = l;
    bus.in_valid = 1'b1;
    for (int t = 0; t < 400; t++) begin
      if (rnd_ar) bus.acc_ready = 1'($urandom_range(0, 1));
      rdy = bus.in_ready;
      @(negedge clock);
      if (rdy) begin
        bus.in_valid = 1'b0;
        return;
      end
    end
    bus.in_valid = 1'b0;
    timeout_fail("send_beat");
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      if (rnd_ar) bus.acc_ready = 1'($urandom_range(0, 1));
      @(negedge clock);
    end
  endtask

  task automatic wait_out(input string name, input logic [ACC_W-1:0] exp_acc, input logic exp_ovf);
    for (int t = 0; t < 300; t++) begin
      if (bus.acc_valid) break;
      @(negedge clock);
    end
    if (!bus.acc_valid) begin
      timeout_fail(name);
    end else begin
      chk({name, "_acc"}, 64'(bus.acc_out), 64'(exp_acc));
      chk({name, "_ovf"}, 64'(bus.ovf), 64'(exp_ovf));
    end
    bus.acc_ready = 1'b1;
    @(negedge clock);
    bus.acc_ready = 1'b0;
  endtask

  initial begin
    #500_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    logic [CNT_W-1:0] l;
    int               eff;
    reset         = 1'b1;
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.len       = '0;
    bus.acc_ready = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    chk("rst_acc_out", 64'(bus.acc_out), 64'd0);
    chk("rst_ovf", 64'(bus.ovf), 64'd0);
    chk("rst_acc_valid", 64'(bus.acc_valid), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

    // len=4, 1..4 back-to-back, consumer always ready
    bus.acc_ready = 1'b1;
    for (int i = 1; i <= 4; i++) send_beat(IN_W'(i), CNT_W'(4));
    chk("t1_valid", 64'(bus.acc_valid), 64'd1);
    chk("t1_in_ready", 64'(bus.in_ready), 64'd0);
    chk("t1_acc", 64'(bus.acc_out), 64'd10);
    chk("t1_ovf", 64'(bus.ovf), 64'd0);
    @(negedge clock);
    chk("t1_drained", 64'(bus.acc_valid), 64'd0);
    bus.acc_ready = 1'b0;

    // len=0 behaves as length 1
    send_beat(18'h3FFFF, CNT_W'(0));
    chk("t2_valid", 64'(bus.acc_valid), 64'd1);
    wait_out("t2", 24'h03FFFF, 1'b0);

    // backpressure with a pending beat held on the input
    send_beat(IN_W'(5), CNT_W'(2));
    send_beat(IN_W'(6), CNT_W'(2));
    bus.in_data  = IN_W'(9);
    bus.len      = CNT_W'(1);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("t3_hold_acc", 64'(bus.acc_out), 64'd11);
      chk("t3_hold_rdy", 64'(bus.in_ready), 64'd0);
    end
    bus.acc_ready = 1'b1;
    @(negedge clock);
    bus.acc_ready = 1'b0;
    chk("t3_idle_rdy", 64'(bus.in_ready), 64'd1);
    chk("t3_idle_valid", 64'(bus.acc_valid), 64'd0);
    @(negedge clock);
    bus.in_valid = 1'b0;
    chk("t3_new_valid", 64'(bus.acc_valid), 64'd1);
    wait_out("t3_new", 24'd9, 1'b0);

    // 65 maximal beats overflow the accumulator
    for (int i = 0; i < 65; i++) send_beat(18'h3FFFF, CNT_W'(65));
`ifdef BM_PROD_ACCUM_SATURATE_EN
    wait_out("t4", 24'hFFFFFF, 1'b1);
`else
    wait_out("t4", 24'h03FFBF, 1'b1);
`endif

    // reset mid-window discards the partial sum
    send_beat(IN_W'(7), CNT_W'(4));
    send_beat(IN_W'(7), CNT_W'(4));
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t5_no_valid", 64'(bus.acc_valid), 64'd0);
      @(negedge clock);
    end
    send_beat(IN_W'(3), CNT_W'(1));
    wait_out("t5", 24'd3, 1'b0);

    // bubbles and a mid-window len change
    send_beat(IN_W'(2), CNT_W'(3));
    idle_cycles(2);
    send_beat(IN_W'(4), CNT_W'(9));
    idle_cycles(2);
    chk("t6_not_yet", 64'(bus.acc_valid), 64'd0);
    send_beat(IN_W'(8), CNT_W'(9));
    chk("t6_valid", 64'(bus.acc_valid), 64'd1);
    wait_out("t6", 24'd14, 1'b0);

    // randomized windows, bubbles, len changes and output backpressure
    rnd_ar = 1'b1;
    for (int w = 0; w < 40; w++) begin
      int r;
      r   = int'($urandom_range(0, 9));
      l   = (r == 9) ? CNT_W'(70) : CNT_W'(r);
      eff = (l == '0) ? 1 : int'(l);
      for (int b = 0; b < eff; b++) begin
        idle_cycles(int'($urandom_range(0, 2)));
        if (l == CNT_W'(70))
          send_beat(18'h3FF00 | IN_W'($urandom_range(0, 255)), (b == 0) ? l : CNT_W'($urandom));
        else
          send_beat(IN_W'($urandom), (b == 0) ? l : CNT_W'($urandom));
      end
    end
    rnd_ar        = 1'b0;
    bus.acc_ready = 1'b1;
    repeat (4) @(negedge clock);
    bus.acc_ready = 1'b0;
    chk("final_drained", 64'(bus.acc_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
